mem_burst_reader: RTL and testbench

- Request-side sequencer placed directly upstream of the single-port SRAM wrapper (mem_sp_sky130).
- Owns the wrapper's addr/wen/wdata/ren port. Accepts single-word writes and burst-read commands, then issues reads honouring the wrapper's tiled-read contract.
- Tracks the 2-cycle read latency and returns read data on a valid/ready stream, buffered in a credit-guarded output FIFO.

---
 rtl/mem_burst_reader.sv | 193 +++++++++++++++++++
 tb/tb_mem_burst_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_burst_reader: write/burst-read sequencer in front of a tiled SRAM.     |
// | Optional perf counters: MEM_BURST_READER_PERF_EN.   Revision: 1.0          |
// +----------------------------------------------------------------------------+
module mem_burst_reader #(
  parameter int DATA_BIT       = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_BIT       = $clog2(DEPTH),
  parameter int TILE_ADDR_BITS = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_BIT-1:0] wr_addr,
  input  logic [DATA_BIT-1:0] wr_data,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_BIT-1:0] cmd_base,
  input  logic [ADDR_BIT:0]   cmd_len,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_BIT-1:0] mem_wdata,
  output logic                mem_ren,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic                out_last,
  output logic                busy
`ifdef MEM_BURST_READER_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_hold_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_BIT-1:0]   r_cur_addr;
  logic [ADDR_BIT:0]     r_remaining;
  logic [ADDR_BIT-1:0]   r_mem_addr;
  logic                  r_p1_v, r_p1_last, r_p2_v, r_p2_last;
  logic [DATA_BIT-1:0]   r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_count;

  logic                  w_issue, w_load, w_stall, w_push, w_pop;
  logic                  w_credit, w_rem_last, w_tile_end;
  logic [CW-1:0]         w_used;
  logic [ADDR_BIT-1:0]   w_next_addr;

  // Credit covers both FIFO occupancy and reads still in the 2-cycle pipe.
  assign w_used      = CW'(r_count) + CW'(r_p1_v) + CW'(r_p2_v);
  assign w_credit    = (w_used < CW'(FIFO_DEPTH));
  assign w_rem_last  = (r_remaining == {{ADDR_BIT{1'b0}}, 1'b1});
  assign w_tile_end  = &r_cur_addr[TILE_ADDR_BITS-1:0];
  assign w_next_addr = (r_cur_addr == ADDR_BIT'(DEPTH - 1)) ? '0 : r_cur_addr + ADDR_BIT'(1);

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    cmd_ready   = 1'b0;
    mem_addr    = r_mem_addr;
    mem_wen     = 1'b0;
    mem_wdata   = '0;
    mem_ren     = 1'b0;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready  = 1'b1;
        cmd_ready = ~wr_valid;
        if (wr_valid) begin
          mem_addr  = wr_addr;
          mem_wen   = 1'b1;
          mem_wdata = wr_data;
        end else if (cmd_valid && (cmd_len != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_ren = 1'b1;
        if (w_credit) begin
          mem_addr = r_cur_addr;
          w_issue  = 1'b1;
          if (w_rem_last || w_tile_end) w_state_nxt = S_HOLD;
        end else begin
          // Re-drive the last issued address so an unheld read stays legal.
          w_stall = 1'b1;
        end
      end
      S_HOLD: begin
        mem_ren     = 1'b1;
        w_state_nxt = (r_remaining != '0) ? S_READ : S_DRAIN;
      end
      default: begin
        if (!r_p1_v) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_p1_v      <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p2_v      <= 1'b0;
      r_p2_last   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_addr <= mem_addr;
      if (w_load) begin
        r_cur_addr  <= cmd_base;
        r_remaining <= cmd_len;
      end else if (w_issue) begin
        r_cur_addr  <= w_next_addr;
        r_remaining <= r_remaining - {{ADDR_BIT{1'b0}}, 1'b1};
      end
      r_p1_v    <= w_issue;
      r_p1_last <= w_issue & w_rem_last;
      r_p2_v    <= r_p1_v;
      r_p2_last <= r_p1_last;
    end
  end

  assign w_push = r_p2_v;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= mem_rdata;
      r_fifo_last[r_wptr] <= r_p2_last;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_fifo_data[r_rptr] : '0;
  assign out_last  = out_valid & r_fifo_last[r_rptr];
  assign busy      = (r_state != S_IDLE);

`ifdef MEM_BURST_READER_PERF_EN
  logic [31:0] r_perf_stall, r_perf_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_hold  <= '0;
    end else begin
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_state == S_HOLD) && (r_perf_hold != '1)) r_perf_hold <= r_perf_hold + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_hold_cnt  = r_perf_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_burst_reader: randomized bench with SRAM model and burst scoreboard. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_burst_reader;
  localparam int DATA_BIT   = 32;
  localparam int DEPTH      = 256;
  localparam int ADDR_BIT   = 8;
  localparam int TILE_WORDS = 128;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                wr_valid = 1'b0, wr_ready;
  logic [ADDR_BIT-1:0] wr_addr = '0;
  logic [DATA_BIT-1:0] wr_data = '0;
  logic                cmd_valid = 1'b0, cmd_ready;
  logic [ADDR_BIT-1:0] cmd_base = '0;
  logic [ADDR_BIT:0]   cmd_len = '0;
  logic [ADDR_BIT-1:0] mem_addr;
  logic                mem_wen, mem_ren;
  logic [DATA_BIT-1:0] mem_wdata, mem_rdata;
  logic                out_valid, out_last, busy;
  logic                out_ready = 1'b1;
  logic [DATA_BIT-1:0] out_data;
`ifdef MEM_BURST_READER_PERF_EN
  logic [31:0] perf_stall_cnt, perf_hold_cnt;
`endif

  mem_burst_reader #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT),
                     .TILE_ADDR_BITS(7), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
`ifdef MEM_BURST_READER_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  // SRAM wrapper model: 2-cycle read latency, garbage when no read is returning.
  logic [DATA_BIT-1:0] sram [DEPTH];
  logic [DATA_BIT-1:0] sr_d1;
  logic                sr_v1;
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    sr_v1     <= mem_ren;
    sr_d1     <= sram[mem_addr];
    mem_rdata <= sr_v1 ? sr_d1 : DATA_BIT'($urandom);
  end

  // Monitor: beat collection and wrapper-contract bookkeeping.
  logic [32:0]         got_q [$];
  int                  ren_cnt, issue_cnt, viol_cnt;
  logic                m_prev_ren, m_prev_issue, m_cur_issue;
  logic [ADDR_BIT-1:0] m_prev_addr;
  always @(negedge clk) begin
    if (rst) begin
      m_prev_ren   = 1'b0;
      m_prev_issue = 1'b0;
      m_prev_addr  = '0;
    end else begin
      m_cur_issue = mem_ren && !(m_prev_ren && (mem_addr == m_prev_addr));
      if (m_prev_issue && (!mem_ren || (int'(mem_addr) / TILE_WORDS != int'(m_prev_addr) / TILE_WORDS)))
        viol_cnt++;
      if (mem_ren && mem_wen) viol_cnt++;
      if (mem_ren) ren_cnt++;
      if (m_cur_issue) issue_cnt++;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      m_prev_ren   = mem_ren;
      m_prev_issue = m_cur_issue;
      m_prev_addr  = mem_addr;
    end
  end

  logic [DATA_BIT-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [32:0] exp_beat(int base, int len, int i);
    return {(i == len - 1), ref_mem[(base + i) % DEPTH]};
  endfunction

  // Issue+hold cycles at full throughput: one per word, one per tile crossing, one trailing.
  function automatic int exp_ren(int base, int len);
    int n = len + 1;
    for (int i = 0; i < len - 1; i++)
      if (((base + i) % DEPTH) % TILE_WORDS == TILE_WORDS - 1) n++;
    return n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DATA_BIT-1:0] d);
    wr_valid = 1'b1; wr_addr = ADDR_BIT'(a); wr_data = d;
    cyc();
    wr_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_cmd(input int base, input int len);
    cmd_valid = 1'b1; cmd_base = ADDR_BIT'(base); cmd_len = (ADDR_BIT+1)'(len);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int total, input bit rnd, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= total && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] obs [8];
    logic [31:0] req [8];
    string       nm  [8];
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    obs = '{32'(out_valid), 32'(busy), 32'(mem_ren), 32'(mem_wen), 32'(mem_addr),
            32'(out_last), 32'(wr_ready), 32'(cmd_ready)};
    req = '{0, 0, 0, 0, 0, 0, 1, 1};
    nm  = '{"out_valid", "busy", "mem_ren", "mem_wen", "mem_addr", "out_last", "wr_ready", "cmd_ready"};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (obs[i] !== req[i]) $display("FAIL reset_%s: got %0h expected %0h", nm[i], obs[i], req[i]);
      else n_pass++;
    end
    cyc();
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEPTH; a++) do_write(a, $urandom);
  endtask

  task automatic test_basic();
    int s, r0, v0;
    bit ok;
    for (int i = 0; i < 4; i++) do_write(4 + i, 32'hA5A5_0001 + 32'(i));
    s = got_q.size(); r0 = ren_cnt; v0 = viol_cnt;
    do_cmd(4, 4);
    wait_done(s + 4, 1'b0, 100, ok);
    n_checks++;
    if (!ok || got_q.size() - s != 4) $display("FAIL basic_done: got %0d beats ok=%0d expected 4", got_q.size() - s, ok);
    else n_pass++;
    for (int i = 0; i < 4 && s + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[s + i] !== exp_beat(4, 4, i)) $display("FAIL basic_beat%0d: got %h expected %h", i, got_q[s + i], exp_beat(4, 4, i));
      else n_pass++;
    end
    n_checks++;
    if (ren_cnt - r0 != exp_ren(4, 4)) $display("FAIL basic_ren_cycles: got %0d expected %0d", ren_cnt - r0, exp_ren(4, 4));
    else n_pass++;
    n_checks++;
    if (viol_cnt != v0) $display("FAIL basic_contract: got %0d violations expected 0", viol_cnt - v0);
    else n_pass++;
  endtask

  task automatic test_tile_and_wrap();
    int bases [2] = '{126, 254};
    int s, r0, v0;
    bit ok;
    foreach (bases[k]) begin
      s = got_q.size(); r0 = ren_cnt; v0 = viol_cnt;
      do_cmd(bases[k], 4);
      wait_done(s + 4, 1'b0, 100, ok);
      n_checks++;
      if (!ok || got_q.size() - s != 4) $display("FAIL cross%0d_done: got %0d beats expected 4", bases[k], got_q.size() - s);
      else n_pass++;
      for (int i = 0; i < 4 && s + i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[s + i] !== exp_beat(bases[k], 4, i))
          $display("FAIL cross%0d_beat%0d: got %h expected %h", bases[k], i, got_q[s + i], exp_beat(bases[k], 4, i));
        else n_pass++;
      end
      n_checks++;
      if (ren_cnt - r0 != exp_ren(bases[k], 4) || viol_cnt != v0)
        $display("FAIL cross%0d_hold: got ren=%0d viol=%0d expected ren=%0d viol=0",
                 bases[k], ren_cnt - r0, viol_cnt - v0, exp_ren(bases[k], 4));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int s, i0, base, unstable;
    bit have, ok;
    logic [DATA_BIT-1:0] first;
    base = int'($urandom_range(0, 119));
    s = got_q.size(); i0 = issue_cnt; unstable = 0; have = 1'b0; first = '0;
    out_ready = 1'b0;
    do_cmd(base, 8);
    repeat (15) begin
      cyc();
      if (out_valid) begin
        if (!have) begin first = out_data; have = 1'b1; end
        else if (out_data !== first) unstable++;
      end
    end
    n_checks++;
    if (issue_cnt - i0 != FIFO_DEPTH) $display("FAIL stall_issues: got %0d expected %0d", issue_cnt - i0, FIFO_DEPTH);
    else n_pass++;
    n_checks++;
    if (!have || first !== exp_beat(base, 8, 0)) $display("FAIL stall_head: got %h valid=%0d expected %h", first, have, exp_beat(base, 8, 0));
    else n_pass++;
    n_checks++;
    if (unstable != 0 || busy !== 1'b1) $display("FAIL stall_stable: got %0d changes busy=%0d expected 0 changes busy=1", unstable, busy);
    else n_pass++;
    wait_done(s + 8, 1'b0, 200, ok);
    n_checks++;
    if (!ok || got_q.size() - s != 8) $display("FAIL stall_count: got %0d beats expected 8", got_q.size() - s);
    else n_pass++;
    for (int i = 0; i < 8 && s + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[s + i] !== exp_beat(base, 8, i)) $display("FAIL stall_beat%0d: got %h expected %h", i, got_q[s + i], exp_beat(base, 8, i));
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int a, s;
    bit ok, busy_seen;
    logic [DATA_BIT-1:0] d;
    a = int'($urandom_range(0, DEPTH - 1)); d = $urandom;
    wr_valid = 1'b1; wr_addr = ADDR_BIT'(a); wr_data = d;
    cmd_valid = 1'b1; cmd_base = ADDR_BIT'(a); cmd_len = '0;
    @(negedge clk);
    n_checks++;
    if (mem_wen !== 1'b1 || cmd_ready !== 1'b0 || mem_addr !== ADDR_BIT'(a) || mem_wdata !== d)
      $display("FAIL collide_write: got wen=%0d cmd_ready=%0d addr=%0d wdata=%h expected 1 0 %0d %h",
               mem_wen, cmd_ready, mem_addr, mem_wdata, a, d);
    else n_pass++;
    cyc();
    wr_valid = 1'b0; ref_mem[a] = d;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL collide_cmd_ready: got %0d expected 1", cmd_ready);
    else n_pass++;
    cyc();
    cmd_valid = 1'b0;
    s = got_q.size(); busy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || mem_ren) busy_seen = 1'b1;
      cyc();
    end
    n_checks++;
    if (busy_seen || got_q.size() != s) $display("FAIL len0_idle: got busy=%0d beats=%0d expected 0 0", busy_seen, got_q.size() - s);
    else n_pass++;
    do_cmd(a, 1);
    wait_done(s + 1, 1'b0, 50, ok);
    n_checks++;
    if (!ok || got_q.size() != s + 1 || got_q[s] !== {1'b1, d})
      $display("FAIL collide_readback: got %h expected %h", (got_q.size() > s) ? got_q[s] : 33'h0, {1'b1, d});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s, base;
    bit ok;
    base = int'($urandom_range(0, DEPTH - 1));
    do_cmd(base, 16);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_wen, mem_ren, out_valid, out_last, busy} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 || out_data !== '0)
      $display("FAIL midrst_outputs: got wen=%0d ren=%0d ov=%0d last=%0d busy=%0d addr=%0d data=%h expected all 0",
               mem_wen, mem_ren, out_valid, out_last, busy, mem_addr, out_data);
    else n_pass++;
    s = got_q.size();
    repeat (20) cyc();
    n_checks++;
    if (got_q.size() != s) $display("FAIL midrst_no_beats: got %0d beats expected 0", got_q.size() - s);
    else n_pass++;
    base = int'($urandom_range(0, DEPTH - 1));
    do_cmd(base, 5);
    wait_done(s + 5, 1'b0, 100, ok);
    n_checks++;
    if (!ok || got_q.size() != s + 5 || got_q[s + 4] !== exp_beat(base, 5, 4) || got_q[s] !== exp_beat(base, 5, 0))
      $display("FAIL midrst_recover: got %0d beats ok=%0d expected 5 matching", got_q.size() - s, ok);
    else n_pass++;
  endtask

  task automatic test_random();
    int s, base, len, v0, bad;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      repeat (int'($urandom_range(1, 4))) do_write(int'($urandom_range(0, DEPTH - 1)), $urandom);
      base = int'($urandom_range(0, DEPTH - 1));
      len  = (it == 5) ? DEPTH : int'($urandom_range(0, 40));
      s = got_q.size(); v0 = viol_cnt; bad = 0;
      do_cmd(base, len);
      wait_done(s + len, 1'b1, len * 6 + 100, ok);
      n_checks++;
      if (!ok || got_q.size() - s != len) $display("FAIL rand%0d_count: got %0d beats ok=%0d expected %0d", it, got_q.size() - s, ok, len);
      else n_pass++;
      for (int i = 0; i < len && s + i < got_q.size(); i++)
        if (got_q[s + i] !== exp_beat(base, len, i)) bad++;
      n_checks++;
      if (bad != 0 || viol_cnt != v0)
        $display("FAIL rand%0d_data: got %0d bad beats %0d violations (base=%0d len=%0d) expected 0 0", it, bad, viol_cnt - v0, base, len);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_tile_and_wrap();
    test_stall();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
